// File: rtl/system_controller_pkg.sv
// rtl/system_controller_pkg.sv - command codes, sequencer states and operand addresses
package system_controller_pkg;

  localparam logic [7:0] CMD_WRITE   = 8'hAA;
  localparam logic [7:0] CMD_READ    = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  localparam int OPERAND_A_ADDR = 0;
  localparam int OPERAND_B_ADDR = 1;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    OP_A,
    OP_B,
    ALU_FUNC
  } state_t;

endpackage

// File: rtl/system_command_sequencer.sv
// rtl/system_command_sequencer.sv - parses UART command frames into register-file and ALU strobes
module system_command_sequencer
  import system_controller_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDRESS_WIDTH  = 4,
  parameter int FUNCTION_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DATA_WIDTH-1:0]     received_data,
  input  logic                      received_data_valid,
  input  logic                      UART_receiver_controller_enable,
  output logic [ADDRESS_WIDTH-1:0]  register_address,
  output logic [DATA_WIDTH-1:0]     register_write_data,
  output logic                      register_write_enable,
  output logic                      register_read_enable,
  output logic [FUNCTION_WIDTH-1:0] ALU_function,
  output logic                      ALU_enable,
  output logic                      ALU_clock_gate_enable,
  output logic                      command_error
);

  state_t                   state;
  // write address is staged so register_address only moves together with its strobe
  logic [ADDRESS_WIDTH-1:0] address_hold;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                 <= IDLE;
      address_hold          <= '0;
      register_address      <= '0;
      register_write_data   <= '0;
      register_write_enable <= 1'b0;
      register_read_enable  <= 1'b0;
      ALU_function          <= '0;
      ALU_enable            <= 1'b0;
      ALU_clock_gate_enable <= 1'b0;
      command_error         <= 1'b0;
    end else begin
      register_write_enable <= 1'b0;
      register_read_enable  <= 1'b0;
      ALU_enable            <= 1'b0;
      command_error         <= 1'b0;
      case (state)
        IDLE: begin
          ALU_clock_gate_enable <= 1'b0;
          if (received_data_valid && UART_receiver_controller_enable) begin
            case (received_data)
              CMD_WRITE:   state <= WR_ADDR;
              CMD_READ:    state <= RD_ADDR;
              CMD_ALU_OP: begin
                state                 <= OP_A;
                ALU_clock_gate_enable <= 1'b1;
              end
              CMD_ALU_NOP: begin
                state                 <= ALU_FUNC;
                ALU_clock_gate_enable <= 1'b1;
              end
              default:     command_error <= 1'b1;
            endcase
          end
        end
        WR_ADDR: begin
          if (received_data_valid) begin
            address_hold <= received_data[ADDRESS_WIDTH-1:0];
            state        <= WR_DATA;
          end
        end
        WR_DATA: begin
          if (received_data_valid) begin
            register_address      <= address_hold;
            register_write_data   <= received_data;
            register_write_enable <= 1'b1;
            state                 <= IDLE;
          end
        end
        RD_ADDR: begin
          if (received_data_valid) begin
            register_address     <= received_data[ADDRESS_WIDTH-1:0];
            register_read_enable <= 1'b1;
            state                <= IDLE;
          end
        end
        OP_A: begin
          ALU_clock_gate_enable <= 1'b1;
          if (received_data_valid) begin
            register_address      <= ADDRESS_WIDTH'(OPERAND_A_ADDR);
            register_write_data   <= received_data;
            register_write_enable <= 1'b1;
            state                 <= OP_B;
          end
        end
        OP_B: begin
          ALU_clock_gate_enable <= 1'b1;
          if (received_data_valid) begin
            register_address      <= ADDRESS_WIDTH'(OPERAND_B_ADDR);
            register_write_data   <= received_data;
            register_write_enable <= 1'b1;
            state                 <= ALU_FUNC;
          end
        end
        ALU_FUNC: begin
          // gate stays open through the ALU_enable cycle; IDLE closes it afterwards
          ALU_clock_gate_enable <= 1'b1;
          if (received_data_valid) begin
            ALU_function <= received_data[FUNCTION_WIDTH-1:0];
            ALU_enable   <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_system_command_sequencer.sv
// tb/tb_system_command_sequencer.sv - randomized frame stimulus checked against a frame-level model
module tb_system_command_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] received_data;
  logic       received_data_valid;
  logic       UART_receiver_controller_enable;
  logic [3:0] register_address;
  logic [7:0] register_write_data;
  logic       register_write_enable;
  logic       register_read_enable;
  logic [3:0] ALU_function;
  logic       ALU_enable;
  logic       ALU_clock_gate_enable;
  logic       command_error;

  int n_vectors     = 0;
  int n_miscompares = 0;

  system_command_sequencer dut (
    .clk                             (clk),
    .reset                           (reset),
    .received_data                   (received_data),
    .received_data_valid             (received_data_valid),
    .UART_receiver_controller_enable (UART_receiver_controller_enable),
    .register_address                (register_address),
    .register_write_data             (register_write_data),
    .register_write_enable           (register_write_enable),
    .register_read_enable            (register_read_enable),
    .ALU_function                    (ALU_function),
    .ALU_enable                      (ALU_enable),
    .ALU_clock_gate_enable           (ALU_clock_gate_enable),
    .command_error                   (command_error)
  );

  always #5 clk = ~clk;

  logic [7:0] frame[$];
  logic [3:0] exp_addr, exp_func;
  logic [7:0] exp_wdata;
  logic       exp_we, exp_re, exp_alu, exp_gate, exp_err;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vectors++;
    if (obs !== exp) begin
      n_miscompares++;
      $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic int frame_len(input logic [7:0] cmd);
    case (cmd)
      8'hAA:   return 3;
      8'hBB:   return 2;
      8'hCC:   return 4;
      8'hDD:   return 2;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    frame.delete();
    exp_addr = '0; exp_func = '0; exp_wdata = '0;
    exp_we = 0; exp_re = 0; exp_alu = 0; exp_gate = 0; exp_err = 0;
  endtask

  task automatic model_step(input bit v, input logic [7:0] b, input bit en);
    exp_we = 0; exp_re = 0; exp_alu = 0; exp_err = 0;
    if (v) begin
      if (frame.size() == 0) begin
        if (en) begin
          if (frame_len(b) == 0) exp_err = 1;
          else frame.push_back(b);
        end
      end else begin
        frame.push_back(b);
        case (frame[0])
          8'hAA: if (frame.size() == 3) begin
            exp_addr = frame[1][3:0]; exp_wdata = frame[2]; exp_we = 1;
          end
          8'hBB: begin exp_addr = frame[1][3:0]; exp_re = 1; end
          8'hCC: begin
            if (frame.size() == 2) begin exp_addr = 4'd0; exp_wdata = frame[1]; exp_we = 1; end
            if (frame.size() == 3) begin exp_addr = 4'd1; exp_wdata = frame[2]; exp_we = 1; end
            if (frame.size() == 4) begin exp_func = frame[3][3:0]; exp_alu = 1; end
          end
          default: begin exp_func = frame[1][3:0]; exp_alu = 1; end
        endcase
        if (frame.size() == frame_len(frame[0])) frame.delete();
      end
    end
    exp_gate = exp_alu || (frame.size() > 0 && (frame[0] == 8'hCC || frame[0] == 8'hDD));
  endtask

  task automatic check_outputs();
    check_eq("register_address", 32'(register_address), 32'(exp_addr));
    check_eq("register_write_data", 32'(register_write_data), 32'(exp_wdata));
    check_eq("register_write_enable", 32'(register_write_enable), 32'(exp_we));
    check_eq("register_read_enable", 32'(register_read_enable), 32'(exp_re));
    check_eq("ALU_function", 32'(ALU_function), 32'(exp_func));
    check_eq("ALU_enable", 32'(ALU_enable), 32'(exp_alu));
    check_eq("ALU_clock_gate_enable", 32'(ALU_clock_gate_enable), 32'(exp_gate));
    check_eq("command_error", 32'(command_error), 32'(exp_err));
  endtask

  task automatic apply(input bit v, input logic [7:0] b, input bit en);
    @(negedge clk);
    received_data                   = b;
    received_data_valid             = v;
    UART_receiver_controller_enable = en;
    model_step(v, b, en);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic send_bytes(input logic [7:0] bytes[$], input bit en);
    foreach (bytes[i]) apply(1'b1, bytes[i], en);
    apply(1'b0, 8'h00, en);
  endtask

  initial begin
    logic [7:0] cmds[4];
    cmds = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    reset = 1'b1;
    received_data = '0;
    received_data_valid = 1'b0;
    UART_receiver_controller_enable = 1'b0;
    model_reset();
    #12;
    check_outputs();
    @(negedge clk);
    reset = 1'b0;

    send_bytes('{8'hAA, 8'h05, 8'h3C}, 1'b1);
    send_bytes('{8'hBB, 8'h07}, 1'b1);
    send_bytes('{8'hCC, 8'h12, 8'h34, 8'h02}, 1'b1);
    send_bytes('{8'hDD, 8'h0F}, 1'b1);
    send_bytes('{8'h55}, 1'b1);
    send_bytes('{8'hAA, 8'hF9}, 1'b0);
    apply(1'b1, 8'hAA, 1'b1);
    send_bytes('{8'h03, 8'h99}, 1'b0);

    // reset lands while the first operand write strobe is high
    apply(1'b1, 8'hCC, 1'b1);
    apply(1'b1, 8'h12, 1'b1);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_outputs();
    @(negedge clk);
    reset = 1'b0;
    send_bytes('{8'hDD, 8'h01}, 1'b1);

    for (int f = 0; f < 300; f++) begin
      int n;
      logic [7:0] c;
      if ($urandom_range(0, 9) == 0) c = 8'($urandom);
      else c = cmds[$urandom_range(0, 3)];
      n = (frame_len(c) == 0) ? 1 : frame_len(c);
      for (int k = 0; k < n; k++) begin
        logic [7:0] b;
        b = (k == 0) ? c : 8'($urandom);
        apply(1'b1, b, $urandom_range(0, 3) != 0);
        for (int g = $urandom_range(0, 2); g > 0; g--)
          apply(1'b0, 8'($urandom), $urandom_range(0, 1) != 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
